// File: rtl/spi_segment_master.sv
// SPI mode-0 master for the segment-controller peripheral port.
// One MSB-first byte per start request; sck, cs_n and mosi are all registered.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cs_n high, waiting for start
// LEAD    | cs_n low, sck low, mosi = bit7 setup before first rise
// SCK_LO  | sck low half-period, mosi presents the next bit
// SCK_HI  | sck high half-period, miso was sampled on entry
// TRAIL   | sck low after last bit, cs_n still low (hold time)
// GAP     | cs_n high deselect time, busy still asserted

module spi_segment_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SCK_LO,
        SCK_HI,
        TRAIL,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    state_t     state, state_nxt;
    logic [7:0] div_cnt, div_cnt_nxt;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] tx_sr, tx_sr_nxt;
    logic [7:0] rx_sr, rx_sr_nxt;
    logic [7:0] rx_data_nxt;
    logic       busy_nxt, done_nxt, sck_nxt, mosi_nxt, cs_n_nxt;
    logic       div_tc;
    logic       accept;

    assign div_tc = (div_cnt == 8'd0);
    // A start seen at the end of GAP is taken on the same edge busy would fall.
    assign accept = start && ((state == IDLE) || ((state == GAP) && div_tc));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= 8'd0;
            bit_cnt <= 4'd0;
            tx_sr   <= 8'h00;
            rx_sr   <= 8'h00;
            rx_data <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            tx_sr   <= tx_sr_nxt;
            rx_sr   <= rx_sr_nxt;
            rx_data <= rx_data_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            sck     <= sck_nxt;
            mosi    <= mosi_nxt;
            cs_n    <= cs_n_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_cnt;
        bit_cnt_nxt = bit_cnt;
        tx_sr_nxt   = tx_sr;
        rx_sr_nxt   = rx_sr;
        rx_data_nxt = rx_data;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        sck_nxt     = sck;
        mosi_nxt    = mosi;
        cs_n_nxt    = cs_n;

        case (state)
            IDLE: begin
            end
            LEAD, SCK_LO: begin
                if (div_tc) begin
                    sck_nxt     = 1'b1;
                    rx_sr_nxt   = {rx_sr[6:0], miso};
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    div_cnt_nxt = DIV_LOAD;
                    state_nxt   = SCK_HI;
                end else begin
                    div_cnt_nxt = div_cnt - 8'd1;
                end
            end
            SCK_HI: begin
                if (div_tc) begin
                    sck_nxt     = 1'b0;
                    div_cnt_nxt = DIV_LOAD;
                    if (bit_cnt == 4'd8) begin
                        state_nxt = TRAIL;
                    end else begin
                        tx_sr_nxt = {tx_sr[6:0], 1'b0};
                        mosi_nxt  = tx_sr[6];
                        state_nxt = SCK_LO;
                    end
                end else begin
                    div_cnt_nxt = div_cnt - 8'd1;
                end
            end
            TRAIL: begin
                if (div_tc) begin
                    cs_n_nxt    = 1'b1;
                    mosi_nxt    = 1'b0;
                    rx_data_nxt = rx_sr;
                    done_nxt    = 1'b1;
                    div_cnt_nxt = DIV_LOAD;
                    state_nxt   = GAP;
                end else begin
                    div_cnt_nxt = div_cnt - 8'd1;
                end
            end
            GAP: begin
                if (div_tc) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    div_cnt_nxt = div_cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (accept) begin
            tx_sr_nxt   = tx_data;
            mosi_nxt    = tx_data[7];
            cs_n_nxt    = 1'b0;
            busy_nxt    = 1'b1;
            bit_cnt_nxt = 4'd0;
            div_cnt_nxt = DIV_LOAD;
            state_nxt   = LEAD;
        end
    end

endmodule

// File: tb/tb_spi_segment_master.sv
// Bench for spi_segment_master: three instances at CLK_DIV 4, 1 and 2 sharing clk/rst.
// Expected done bytes/times go into a scoreboard; a monitor pops them on each done pulse.

module tb_spi_segment_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] start = 3'b000;
    logic [2:0] sck, mosi, miso, cs_n, busy, done;
    logic [7:0] tx_data [3];
    logic [7:0] rx_data [3];
    logic [7:0] p_sr = 8'h00;
    logic [7:0] mlog = 8'h00;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int w_e0 [3] = '{0, 0, 0};
    int w_nx [3] = '{0, 0, 0};

    typedef struct {
        int         idx;
        logic [7:0] rx;
        int         at;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    spi_segment_master #(.CLK_DIV(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start[0]), .tx_data(tx_data[0]), .rx_data(rx_data[0]),
        .busy(busy[0]), .done(done[0]), .sck(sck[0]), .mosi(mosi[0]), .miso(miso[0]), .cs_n(cs_n[0]));
    spi_segment_master #(.CLK_DIV(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start[1]), .tx_data(tx_data[1]), .rx_data(rx_data[1]),
        .busy(busy[1]), .done(done[1]), .sck(sck[1]), .mosi(mosi[1]), .miso(miso[1]), .cs_n(cs_n[1]));
    spi_segment_master #(.CLK_DIV(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start[2]), .tx_data(tx_data[2]), .rx_data(rx_data[2]),
        .busy(busy[2]), .done(done[2]), .sck(sck[2]), .mosi(mosi[2]), .miso(miso[2]), .cs_n(cs_n[2]));

    // Instances 0 and 2 loop back; instance 1 talks to a peripheral returning 8'h3C.
    assign miso[0] = mosi[0];
    assign miso[2] = mosi[2];
    assign miso[1] = p_sr[7];

    always @(negedge cs_n[1]) p_sr = 8'h3C;
    always @(negedge sck[1]) if (!cs_n[1]) p_sr = {p_sr[6:0], 1'b0};
    always @(posedge sck[1]) mlog = {mlog[6:0], mosi[1]};

    function automatic int div(input int i);
        case (i)
            0: return 4;
            1: return 1;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic sb_count(input int i, output int n);
        n = 0;
        foreach (sb[j]) if (sb[j].idx == i) n++;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation for that instance.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (done[i]) begin
                    int f;
                    f = -1;
                    foreach (sb[j]) if (f < 0 && sb[j].idx == i) f = j;
                    if (f < 0) begin
                        chk($sformatf("unexpected_done%0d", i), 1, 0);
                    end else begin
                        chk($sformatf("rx_data%0d", i), int'(rx_data[i]), int'(sb[f].rx));
                        chk($sformatf("done_time%0d", i), cyc, sb[f].at);
                        sb.delete(f);
                    end
                end
            end
        end
    end

    // Waveform model: after edge E0+k, sck = odd half-period index up to 15, cs_n high from 17*D.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (w_nx[i] > 0 && !rst) begin
                int d, k, kk, h;
                d = div(i);
                k = cyc - w_e0[i];
                if (k == w_nx[i] * 18 * d) begin
                    chk($sformatf("end_busy%0d", i), int'(busy[i]), 0);
                    chk($sformatf("end_cs_n%0d", i), int'(cs_n[i]), 1);
                    chk($sformatf("end_sck%0d", i), int'(sck[i]), 0);
                    chk($sformatf("end_mosi%0d", i), int'(mosi[i]), 0);
                end else if (k >= 0 && k < w_nx[i] * 18 * d) begin
                    kk = k % (18 * d);
                    h  = kk / d;
                    chk($sformatf("sck%0d", i), int'(sck[i]), ((h % 2 == 1) && (h <= 15)) ? 1 : 0);
                    chk($sformatf("cs_n%0d", i), int'(cs_n[i]), (kk >= 17 * d) ? 1 : 0);
                    chk($sformatf("busy%0d", i), int'(busy[i]), 1);
                end
            end
        end
    end

    task automatic launch(input int i, input logic [7:0] b, input logic [7:0] exp_rx,
                          input bit push, output int e0);
        @(negedge clk);
        tx_data[i] = b;
        start[i]   = 1'b1;
        e0 = cyc + 1;
        if (push) begin
            sb.push_back('{i, exp_rx, e0 + 17 * div(i)});
            w_e0[i] = e0;
            w_nx[i] = 1;
        end else begin
            w_nx[i] = 0;
        end
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic drain(input int i, input int cycles, input string nm);
        int n;
        repeat (cycles) @(negedge clk);
        sb_count(i, n);
        chk(nm, n, 0);
        for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].idx == i) sb.delete(j);
    endtask

    task automatic reset_checks(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_cs_n%0d", tag, i), int'(cs_n[i]), 1);
            chk($sformatf("%s_sck%0d", tag, i), int'(sck[i]), 0);
            chk($sformatf("%s_mosi%0d", tag, i), int'(mosi[i]), 0);
            chk($sformatf("%s_busy%0d", tag, i), int'(busy[i]), 0);
            chk($sformatf("%s_done%0d", tag, i), int'(done[i]), 0);
            chk($sformatf("%s_rx%0d", tag, i), int'(rx_data[i]), 0);
        end
    endtask

    initial begin
        int e0, n, hi, guard;
        logic prev;
        for (int i = 0; i < 3; i++) tx_data[i] = 8'h00;

        #2 rst = 1'b1;
        #1 reset_checks("por");
        @(negedge clk);
        rst = 1'b0;

        // Loopback A5 at CLK_DIV=4.
        launch(0, 8'hA5, 8'hA5, 1'b1, e0);
        drain(0, 80, "d4_a5_missing_done");

        // CLK_DIV=1 against the 3C peripheral while sending 81.
        launch(1, 8'h81, 8'h3C, 1'b1, e0);
        drain(1, 25, "d1_3c_missing_done");
        chk("d1_mosi_bits", int'(mlog), 8'h81);

        // Start pulsed at E0+5 with new data must be ignored.
        launch(0, 8'h6B, 8'h6B, 1'b1, e0);
        repeat (4) @(negedge clk);
        tx_data[0] = 8'hFF;
        start[0]   = 1'b1;
        @(negedge clk);
        start[0]   = 1'b0;
        drain(0, 120, "d4_6b_missing_done");
        chk("d4_rx_hold", int'(rx_data[0]), 8'h6B);

        // Back-to-back with start held, CLK_DIV=2.
        @(negedge clk);
        tx_data[2] = 8'h12;
        start[2]   = 1'b1;
        e0 = cyc + 1;
        sb.push_back('{2, 8'h12, e0 + 34});
        sb.push_back('{2, 8'hFE, e0 + 36 + 34});
        w_e0[2] = e0;
        w_nx[2] = 2;
        @(negedge clk);
        tx_data[2] = 8'hFE;
        hi = 0;
        while (cyc < e0 + 36) begin
            @(negedge clk);
            if (cs_n[2]) hi++;
        end
        start[2] = 1'b0;
        chk("d2_cs_n_gap", hi, 2);
        chk("d2_second_cs_fall", int'(cs_n[2]), 0);
        drain(2, 50, "d2_missing_done");

        // Reset after the third rising sck edge, then a clean 5A transfer.
        launch(0, 8'hC3, 8'hC3, 1'b0, e0);
        n = 0;
        guard = 0;
        prev = sck[0];
        while (n < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (sck[0] && !prev) n++;
            prev = sck[0];
        end
        chk("rst_wait_sck_rises", n, 3);
        #2 rst = 1'b1;
        #1 reset_checks("mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        launch(0, 8'h5A, 8'h5A, 1'b1, e0);
        drain(0, 80, "d4_5a_missing_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule
